// File: rtl/pe_sched_pkg.sv
// Shared types and constants for the PE row scheduler: FSM state encoding,
// pipeline depth and default widths.
package pe_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    localparam int PIPE_DEPTH     = 3;
    localparam int DEF_NUM_PE     = 4;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_LEN_WIDTH  = 8;
    localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/pe_sched_pipe.sv
// Valid/address shift register for the read -> load -> write tile pipeline.
// Deasserting advance freezes every stage at once.
module pe_sched_pipe
    import pe_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  s0_valid,
    output logic [ADDR_WIDTH-1:0] s0_addr,
    output logic                  s1_valid,
    output logic                  s2_valid,
    output logic [ADDR_WIDTH-1:0] s2_addr
);

    logic [PIPE_DEPTH-1:0] valid_q;
    logic [ADDR_WIDTH-1:0] addr_q [PIPE_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else if (advance) begin
            valid_q   <= {valid_q[PIPE_DEPTH-2:0], in_valid};
            addr_q[0] <= in_addr;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign s0_valid = valid_q[0];
    assign s0_addr  = addr_q[0];
    assign s1_valid = valid_q[1];
    assign s2_valid = valid_q[PIPE_DEPTH-1];
    assign s2_addr  = addr_q[PIPE_DEPTH-1];

endmodule

// File: rtl/pe_row_sched.sv
// Sequences one PE row over len tiles: operand read, PE load, result write.
// Optional stall counter output enabled by defining PE_SCHED_STALL_CNT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; len sampled here only
// ST_RUN   | issuing operand reads, one tile per unstalled cycle
// ST_DRAIN | all reads issued; waiting for last write to be accepted
// ST_DONE  | one-cycle completion pulse, then back to idle
module pe_row_sched
    import pe_sched_pkg::*;
#(
    parameter int NUM_PE     = DEF_NUM_PE,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  set_reg,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_ready
`ifdef PE_SCHED_STALL_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_cnt
`endif
);

    // The schedule is independent of row width; only sanity-check it.
    if (NUM_PE < 1) begin : g_bad_num_pe
        $error("pe_row_sched: NUM_PE must be at least 1");
    end

    sched_state_t          state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  rd_cnt;
    logic                  stall;
    logic                  in_valid;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic                  s0_valid;
    logic                  s1_valid;
    logic                  s2_valid;
    logic [ADDR_WIDTH-1:0] last_addr;

    assign stall     = s2_valid & ~wr_ready;
    assign last_addr = ADDR_WIDTH'(len_q - 1'b1);

    always_comb begin
        in_valid = 1'b0;
        in_addr  = ADDR_WIDTH'(rd_cnt);
        case (state)
            ST_IDLE: begin
                in_valid = start && (len != '0);
                in_addr  = '0;
            end
            ST_RUN:  in_valid = (rd_cnt < len_q);
            default: in_valid = 1'b0;
        endcase
    end

    pe_sched_pipe #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (~stall),
        .in_valid (in_valid),
        .in_addr  (in_addr),
        .s0_valid (s0_valid),
        .s0_addr  (rd_addr),
        .s1_valid (s1_valid),
        .s2_valid (s2_valid),
        .s2_addr  (wr_addr)
    );

    // A stalled write freezes the pipe, so read and load strobes are masked.
    assign rd_en   = s0_valid & ~stall;
    assign set_reg = s1_valid & ~stall;
    assign wr_en   = s2_valid;
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            len_q  <= '0;
            rd_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q <= len;
                        if (len != '0) begin
                            state  <= ST_RUN;
                            rd_cnt <= LEN_WIDTH'(1);
                        end else begin
                            state  <= ST_DONE;
                            rd_cnt <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (!stall && in_valid) begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                    if (rd_en && (rd_cnt == len_q)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (wr_en && wr_ready && (wr_addr == last_addr)) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PE_SCHED_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((state == ST_IDLE) && start) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/pe_row_sched.md
Name: pe_row_sched

Overview:
- Scheduler that sequences one row of NUM_PE adder PEs across a vector of len tiles.
- Issues operand-buffer reads and drives the shared PE set_reg enable, so each tile is added exactly once.
- Issues result-buffer writes, with backpressure from the result side.
- Sits between the softmax top-level control (start/done) and the PE row plus its operand/result SRAM buffers.

Parameters:
- NUM_PE, 4, PEs in the row; one tile = NUM_PE element pairs; informational only, does not affect the schedule.
- ADDR_WIDTH, 8, operand/result buffer address width.
- LEN_WIDTH, 8, width of the tile-count input.
- CNT_WIDTH, 16, width of the optional stall counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run a job; sampled in IDLE only.
- len  in  LEN_WIDTH  tile count, latched on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- rd_en  out  1  operand buffer read strobe; data appears on PE in1/in2 the next cycle and holds until the next rd_en.
- rd_addr  out  ADDR_WIDTH  operand tile address.
- set_reg  out  1  PE psum register load enable, broadcast to the row.
- wr_en  out  1  result write request; held until accepted.
- wr_addr  out  ADDR_WIDTH  result tile address.
- wr_ready  in  1  result side accepts the write when wr_en && wr_ready.
- stall_cnt  out  CNT_WIDTH  present only under the optional feature.

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, set_reg=0, wr_en=0, rd_addr=0, wr_addr=0, state=IDLE, all counters 0, all pipeline valids 0.
- States:
  - IDLE -> RUN on start with len!=0.
  - IDLE -> DONE on start with len==0: no reads or writes; done pulses the cycle after start.
  - RUN -> DRAIN after the read of tile len-1 issues.
  - DRAIN -> DONE when the write of tile len-1 is accepted.
  - DONE -> IDLE unconditionally after one cycle; done=1 only in DONE.
- busy=1 in RUN, DRAIN and DONE.
- Three-stage pipeline per tile k:
  - S0: rd_en=1, rd_addr=k.
  - S1: set_reg=1, loads the PE register.
  - S2: psum_out valid, wr_en=1, wr_addr=k.
- Unstalled throughput is one tile/cycle. Latency from start to first wr_en is 3 cycles; start to done is len+3 cycles.
- Stall: when S2 holds wr_en=1 and wr_ready=0, the whole pipe freezes.
  - rd_en=0 and set_reg=0, so the PE holds its value and the buffer holds its data.
  - wr_en and wr_addr stay stable.
  - No address advances.
  - On the cycle wr_ready=1 the write completes and the pipe advances normally in that same cycle.
- Addresses count up from 0 with no wrap within a job; len must be at most 2^ADDR_WIDTH.
- start while busy is ignored; len is not re-sampled.
- wr_ready=1 with wr_en=0 has no effect.
- Reset mid-job: immediate return to reset values; the PE register content is don't-care.

Optional Feature:
- Macro: PE_SCHED_STALL_CNT_EN.
- With the macro defined:
  - stall_cnt port exists.
  - Cleared on accepted start; increments each cycle with wr_en && !wr_ready.
  - Saturates at all-ones; holds after done until the next start.
- Without the macro: the port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package pe_sched_pkg holds:
  - the state encoding (IDLE, RUN, DRAIN, DONE);
  - pipeline stage count localparam PIPE_DEPTH=3;
  - default width constants.
- Sub-module pe_sched_pipe:
  - valid/address shift register with a global freeze input;
  - instantiated once in pe_row_sched, which keeps the FSM and read counter.

Test Plan:
- Reset: assert rst_n=0 mid-RUN -> all outputs 0 asynchronously; next start len=2 runs cleanly.
- Basic: start, len=4, wr_ready=1 -> rd_addr 0..3 on cycles 1..4; set_reg on cycles 2..5; wr_addr 0..3 on cycles 3..6; done on cycle 7.
- Backpressure: len=3, wr_ready=0 for 2 cycles at the first wr_en -> wr_addr=0 held 3 cycles, rd_en/set_reg low during stall, no skipped or duplicated address, done delayed by 2 cycles; with the macro defined, stall_cnt=2.
- Zero length: start, len=0 -> no rd_en/set_reg/wr_en; done pulses on the next cycle; busy high for one cycle.
- Start while busy: second start during RUN with len=9 -> ignored; job completes with the original len=4; exactly one done.
- Back-to-back: start asserted on the IDLE cycle right after done -> second job begins with rd_addr restarting at 0.
